// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch unit.
// Holds the FSM state enum and address geometry.
package pc_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int WAIT_W = 4;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    ST_RST,
    ST_REQ,
    ST_HOLD,
    ST_DROP,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts consecutive unacknowledged fetch cycles.
// Flags expiry on the MAX_WAIT-th such cycle.
module fetch_wait_timer
  import pc_fetch_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LIMIT =
    WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] cnt;

  assign expired = en && !clear && (cnt == LIMIT);

  // wait counter: clear wins over count
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch PC sequencer and imem handshake.
// Optional fetch timeout: define PC_FETCH_TIMEOUT_EN.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              imem_ack,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_4_out,
  output logic              if_id_write,
  output logic              if_flush,
  output logic              fault
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("pc_fetch: MAX_WAIT must be 1..15");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] out_pc_d, out_pc4_d;
  logic              write_d, flush_d;
  logic [ADDR_W-1:0] target;
  logic              timeout;

  assign target    = redirect_target & ~32'h3;
  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = pc_q;

`ifdef PC_FETCH_TIMEOUT_EN
  logic waiting;
  logic tmr_en;
  logic tmr_clr;

  assign waiting = (state_q == ST_REQ) ||
                   (state_q == ST_DROP);
  assign tmr_en  = waiting && !imem_ack;
  assign tmr_clr = !waiting || imem_ack ||
                   redirect_valid;

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (tmr_en),
    .clear   (tmr_clr),
    .expired (timeout)
  );

  assign fault = (state_q == ST_FAULT);
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  // next-state, next-PC and IF/ID strobe decode
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    out_pc_d  = pc_out;
    out_pc4_d = pc_4_out;
    write_d   = 1'b0;
    flush_d   = 1'b0;
    unique case (state_q)
      ST_RST: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d    = target;
          flush_d = 1'b1;
          state_d = imem_ack ? ST_REQ : ST_DROP;
        end else if (imem_ack && !stall) begin
          out_pc_d  = pc_q;
          out_pc4_d = pc_q + PC_STEP;
          write_d   = 1'b1;
          pc_d      = pc_q + PC_STEP;
        end else if (imem_ack) begin
          hold_d  = pc_q;
          pc_d    = pc_q + PC_STEP;
          state_d = ST_HOLD;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = target;
          flush_d = 1'b1;
          state_d = ST_REQ;
        end else if (!stall) begin
          out_pc_d  = hold_q;
          out_pc4_d = hold_q + PC_STEP;
          write_d   = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect_valid) begin
          pc_d = target;
        end
        if (imem_ack) begin
          state_d = ST_REQ;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RST;
      pc_q        <= RESET_PC;
      hold_q      <= '0;
      pc_out      <= '0;
      pc_4_out    <= '0;
      if_id_write <= 1'b0;
      if_flush    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_q      <= hold_d;
      pc_out      <= out_pc_d;
      pc_4_out    <= out_pc4_d;
      if_id_write <= write_d;
      if_flush    <= flush_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch.
// Timeout section follows PC_FETCH_TIMEOUT_EN.
module tb_pc_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_out;
  logic [31:0] pc_4_out;
  logic        if_id_write;
  logic        if_flush;
  logic        fault;

  int checks;
  int failures;

  pc_fetch #(
    .RESET_PC (32'h0000_0000),
    .MAX_WAIT (15)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_ack        (imem_ack),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .pc_out          (pc_out),
    .pc_4_out        (pc_4_out),
    .if_id_write     (if_id_write),
    .if_flush        (if_flush),
    .fault           (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag,
                         input logic req,
                         input logic wr,
                         input logic fl);
    chk({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
    chk({tag, ".write"}, {31'd0, if_id_write}, {31'd0, wr});
    chk({tag, ".flush"}, {31'd0, if_flush},    {31'd0, fl});
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    imem_ack        = 1'b0;
    tick();
    tick();

    chk_ctl("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.addr",  imem_addr, 32'h0);
    chk("rst.pc",    pc_out,    32'h0);
    chk("rst.pc4",   pc_4_out,  32'h0);
    chk("rst.fault", {31'd0, fault}, 32'd0);

    reset = 1'b1;
    tick();
    chk_ctl("rel", 1'b1, 1'b0, 1'b0);
    chk("rel.addr", imem_addr, 32'h0);

    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b.pc",   pc_out,   32'(i * 4));
      chk("b2b.pc4",  pc_4_out, 32'(i * 4 + 4));
      chk("b2b.addr", imem_addr, 32'(i * 4 + 4));
      chk_ctl("b2b", 1'b1, 1'b1, 1'b0);
    end
    imem_ack = 1'b0;
    tick();
    chk_ctl("wait", 1'b1, 1'b0, 1'b0);
    chk("wait.addr", imem_addr, 32'hC);

    imem_ack = 1'b1;
    tick();
    chk("pre.addr", imem_addr, 32'h10);

    stall = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk_ctl("hold1", 1'b0, 1'b0, 1'b0);
    imem_ack = 1'b1;
    tick();
    tick();
    chk_ctl("hold3", 1'b0, 1'b0, 1'b0);
    imem_ack = 1'b0;
    stall = 1'b0;
    tick();
    chk_ctl("unhold", 1'b1, 1'b1, 1'b0);
    chk("unhold.pc",   pc_out,    32'h10);
    chk("unhold.pc4",  pc_4_out,  32'h14);
    chk("unhold.addr", imem_addr, 32'h14);

    redirect_valid  = 1'b1;
    redirect_target = 32'h103;
    tick();
    redirect_valid = 1'b0;
    chk_ctl("rd", 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("drop", 1'b0, 1'b0, 1'b0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk_ctl("stale", 1'b1, 1'b0, 1'b0);
    chk("stale.addr", imem_addr, 32'h100);
    chk("stale.pc",   pc_out,    32'h10);

    imem_ack        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk_ctl("rdack", 1'b1, 1'b0, 1'b1);
    chk("rdack.addr", imem_addr, 32'h200);
    tick();
    chk_ctl("rdack2", 1'b1, 1'b1, 1'b0);
    chk("rdack2.pc",   pc_out,    32'h200);
    chk("rdack2.addr", imem_addr, 32'h204);

    stall = 1'b1;
    tick();
    imem_ack        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    tick();
    redirect_valid = 1'b0;
    stall = 1'b0;
    chk_ctl("rdstall", 1'b1, 1'b0, 1'b1);
    chk("rdstall.addr", imem_addr, 32'h300);
    chk("rdstall.pc",   pc_out,    32'h200);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk_ctl("rdstall2", 1'b1, 1'b1, 1'b0);
    chk("rdstall2.pc", pc_out, 32'h300);

    redirect_valid  = 1'b1;
    redirect_target = 32'h400;
    tick();
    redirect_target = 32'h500;
    tick();
    redirect_valid = 1'b0;
    chk_ctl("drop_rd", 1'b0, 1'b0, 1'b0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk_ctl("drop_rd2", 1'b1, 1'b0, 1'b0);
    chk("drop_rd2.addr", imem_addr, 32'h500);

    imem_ack        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_ack = 1'b0;
    chk("wrap.pc",   pc_out,    32'hFFFF_FFFC);
    chk("wrap.pc4",  pc_4_out,  32'h0);
    chk("wrap.addr", imem_addr, 32'h0);
    chk("wrap.fault", {31'd0, fault}, 32'd0);

    reset = 1'b0;
    tick();
    chk_ctl("midrst", 1'b0, 1'b0, 1'b0);
    chk("midrst.pc4", pc_4_out, 32'h0);
    reset    = 1'b1;
    imem_ack = 1'b1;
    tick();
    chk_ctl("rstack", 1'b1, 1'b0, 1'b0);
    tick();
    imem_ack = 1'b0;
    chk_ctl("rstack2", 1'b1, 1'b1, 1'b0);
    chk("rstack2.pc", pc_out, 32'h0);

`ifdef PC_FETCH_TIMEOUT_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      tick();
    end
    chk("to14.fault", {31'd0, fault}, 32'd0);
    chk_ctl("to14", 1'b1, 1'b0, 1'b0);
    tick();
    chk("to15.fault", {31'd0, fault}, 32'd1);
    chk_ctl("to15", 1'b0, 1'b0, 1'b0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("fltrd.fault", {31'd0, fault}, 32'd1);
    chk_ctl("fltrd", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk("fltclr.fault", {31'd0, fault}, 32'd0);
    reset = 1'b1;
    tick();
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("nofault", {31'd0, fault}, 32'd0);
    end
    chk_ctl("nofault", 1'b1, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter MAX_WAIT, default 15, range 1..15, SHALL be the number of unacknowledged request cycles before a fault (timeout build only).
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous active-low reset; 0 on a rising clk edge SHALL reset the block.
REQ-005 stall  in  1  the IF/ID register cannot accept a new fetch this cycle.
REQ-006 redirect_valid  in  1  a branch or jump was resolved; fetch SHALL restart at redirect_target.
REQ-007 redirect_target  in  32  the new PC; bits [1:0] SHALL be forced to 0.
REQ-008 imem_ack  in  1  instruction memory has completed the current request.
REQ-009 imem_req  out  1  request to instruction memory, level-held until acknowledged.
REQ-010 imem_addr  out  32  the fetch address, valid while imem_req=1.
REQ-011 pc_out, pc_4_out  out  32 each  the PC of the delivered fetch, and that PC plus 4, driven to IF/ID.
REQ-012 if_id_write  out  1  one-cycle pulse; IF/ID SHALL load pc_out/pc_4_out.
REQ-013 if_flush  out  1  one-cycle pulse; IF/ID SHALL clear.
REQ-014 fault  out  1  sticky fetch timeout.

Function
REQ-015 The block SHALL use the states RST, REQ, HOLD, DROP and FAULT.
REQ-016 RST SHALL go to REQ unconditionally; imem_req SHALL first assert in the cycle after reset deasserts.
REQ-017 In REQ, imem_req=1 and imem_addr=pc.
- If imem_ack=1 and stall=0 in cycle N, then at N+1: pc_out=pc, pc_4_out=pc+4, if_id_write=1, pc advanced by 4, state REQ (back-to-back fetch).
REQ-018 In REQ, imem_ack=1 with stall=1 SHALL store the fetched PC and go to HOLD, with imem_req=0.
- In HOLD, the first cycle with stall=0 SHALL deliver the stored PC as in REQ-017 and return to REQ.
REQ-019 redirect_valid=1 SHALL set pc=redirect_target and pulse if_flush next cycle with if_id_write=0, taking priority over stall and ack. Next state:
- DROP, if a request is outstanding without ack that cycle.
- REQ, if imem_ack=1 that same cycle; the acked data SHALL be discarded.
- REQ, from HOLD; the stored PC SHALL be discarded.
REQ-020 DROP SHALL hold imem_req=0, wait for the stale imem_ack, discard it, then go to REQ at the redirect PC.
- A further redirect in DROP SHALL update pc only.
REQ-021 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag raised.
REQ-022 imem_ack outside REQ and DROP SHALL be ignored.
REQ-023 In FAULT: imem_req=0, fault=1, redirect and stall ignored, until reset.

Reset
REQ-024 On reset=0:
- state=RST, pc=RESET_PC, imem_addr=RESET_PC
- pc_out=0, pc_4_out=0
- imem_req=0, if_id_write=0, if_flush=0, fault=0
- wait counter=0
REQ-025 Reset asserted mid-request SHALL abandon the request with no delivery.

Configuration
REQ-026 With PC_FETCH_TIMEOUT_EN defined:
- A 4-bit wait counter SHALL count consecutive REQ or DROP cycles without ack, clearing on ack or redirect.
- Reaching MAX_WAIT SHALL enter FAULT.
REQ-027 Without PC_FETCH_TIMEOUT_EN: no counter, fault tied to 0, FAULT unreachable, waits unbounded.

Structure
REQ-028 Package pc_fetch_pkg SHALL hold the state enum, PC_STEP=4 and ADDR_W=32.
REQ-029 Sub-module fetch_wait_timer (the wait counter plus compare) SHALL be instantiated only under PC_FETCH_TIMEOUT_EN; all other logic stays in pc_fetch.

Verification
REQ-030 Reset release, imem_ack held 1, stall=0 -> imem_addr 0,4,8 on consecutive cycles; pc_out 0,4,8 with pc_4_out 4,8,12; if_id_write=1 each cycle.
REQ-031 stall=1 for 3 cycles while ack arrives at PC 0x10 -> HOLD, imem_req=0; on stall release, pc_out=0x10, if_id_write pulse, next imem_addr=0x14.
REQ-032 redirect to 0x103 while a request is outstanding, ack 2 cycles later -> if_flush pulse, target 0x100; stale ack discarded, with no if_id_write for it; next imem_addr=0x100.
REQ-033 redirect and imem_ack in the same cycle, and separately redirect with stall=1 -> if_flush=1, if_id_write=0, fetch resumes at target.
REQ-034 pc=0xFFFF_FFFC, ack -> pc_4_out=0, next imem_addr=0.
REQ-035 With PC_FETCH_TIMEOUT_EN and MAX_WAIT=15, no ack for 15 cycles -> fault=1, imem_req=0, redirect ignored; reset=0 clears. Without the macro, no fault after 100 cycles.
